dm_access_arbiter: RTL and testbench
====================================

// Module: dm_access_arbiter
// PURPOSE
// - Shares the single-port, word-wide data memory between the pipeline MEM stage (port A) and a
//   debug/DMA requester (port B).
// - Sequences sub-word stores as a 2-cycle read-modify-write (RMW), because the RAM writes whole words only.
// - Performs load byte/half extraction and sign/zero extension.
// - Sits between the MEM stage and the DM array; drives the stall request back to the hazard unit.
// PARAMETERS
// - AW          12  word-address width of the memory (4096 words)
// - STARVE_MAX  4   consecutive denied cycles of B before B is forced ahead of A
// PORTS
// - clk          in   1   single clock, rising edge
// - reset        in   1   synchronous, active-high
// - a_req        in   1   A access request (level, held until a_ready)
// - a_we         in   1   1=store 0=load
// - a_op         in   3   0 word, 1 byte-u, 2 half-u, 3 byte-s, 4 half-s (sign ignored on stores)
// - a_addr       in   32  byte address
// - a_wdata      in   32  store data; sub-word stores take the low bits
// - a_rdata      out  32  load result, valid when a_ready && !a_we
// - a_ready      out  1   access completes this cycle
// - a_err        out  1   misaligned access; qualified by a_ready
// - a_stall      out  1   a_req && !a_ready (to hazard unit)
// - b_req, b_we, b_op, b_addr, b_wdata, b_rdata, b_ready, b_err   same as A
// - mem_we       out  1   word write strobe to RAM
// - mem_addr     out  AW  word index = addr[AW+1:2]
// - mem_wdata    out  32  full word to write
// - mem_rdata    in   32  combinational read of ram[mem_addr]
// BEHAVIOUR
// Reset
// - State IDLE, starve_cnt=0, all holding registers 0.
// - All ready/err/mem_we outputs 0; rdata outputs 0.
// Arbitration (IDLE only)
// - A wins whenever a_req, unless b_req && starve_cnt==STARVE_MAX; then B wins.
// - starve_cnt increments each cycle b_req is denied, saturating at STARVE_MAX.
// - starve_cnt clears when B is granted or b_req is low.
// - The grant is held for the whole RMW. No new grant is issued in RMW_WR.
// Alignment
// - Word requires addr[1:0]==0; half requires addr[0]==0.
// - A misaligned access completes in 1 cycle: ready=1, err=1, mem_we=0, rdata=0.
// Load, 1 cycle
// - In IDLE: mem_addr driven from the granted port; ready=1 in the same cycle.
// - rdata = lane extract of mem_rdata: byte lane addr[1:0], half lane addr[1].
// - Zero-extended for op 1/2, sign-extended for op 3/4, whole word for op 0.
// Word store, 1 cycle
// - In IDLE: mem_we=1, mem_wdata=wdata, ready=1.
// Sub-word store, 2 cycles (FSM IDLE -> RMW_WR -> IDLE)
// - IDLE cycle: read mem_rdata, merge the byte/half into its lane, and register merged word, word index,
//   and owner. ready=0, mem_we=0.
// - RMW_WR cycle: mem_we=1 with the registered word and index; owner ready=1; return to IDLE.
// - The requester must hold req and inputs stable until ready. Inputs are not re-sampled in RMW_WR.
// Other rules
// - Non-owner ready is always 0; both readys are never 1 in the same cycle.
// - Reset during RMW_WR aborts the access: no write that cycle; state becomes IDLE.
// - Back-to-back accesses: after ready in RMW_WR, the next grant is evaluated in the following IDLE cycle.
// - The port is purely combinational apart from the FSM, the holding registers and starve_cnt.
// STRUCTURE
// - Shared package dm_pkg: MEMOP_WORD/BU/HU/BS/HS constants (0..4), state encoding IDLE/RMW_WR.
// - Sub-module dm_lane_unit (combinational), instanced once on the granted port's mux outputs:
//   - inputs: op, addr[1:0], word, wdata
//   - outputs: extended load data, merged store word, misalign flag
// - Top level holds: port mux, FSM, starve counter, holding registers.
// TESTING
// - Word store/load: A stores 0xDEADBEEF @0x10, then loads it
//   -> mem_we pulse 1 cycle, a_ready the same cycle, a_rdata=0xDEADBEEF.
// - RMW sb: word @0x20 = 0x11223344; A stores byte 0xAB at 0x21
//   -> cycle 1: a_ready=0, mem_we=0; cycle 2: mem_we=1, mem_wdata=0x1122AB44, a_ready=1.
// - Extension: word = 0x80FF7F01
//   -> lb@+2 = 0xFFFFFFFF; lbu@+3 = 0x00000080; lh@+2 = 0xFFFF80FF; lhu@+0 = 0x00007F01.
// - Starvation: a_req and b_req held high, one word access each per cycle
//   -> B granted on the 5th cycle (STARVE_MAX=4), a_stall=1 that cycle, then A resumes.
// - Misalign: sw @0x13, lh @0x21 -> err=1, ready=1, mem_we never asserted, rdata=0.
// - Reset during RMW_WR: sh 0xBEEF @0x40, reset asserted in cycle 2
//   -> no write, word @0x40 unchanged, state IDLE, all outputs 0.

Source files
------------

// File: rtl/dm_pkg.sv
// dm_pkg: memory op codes and arbiter state encoding shared by the data-memory arbiter.
package dm_pkg;
  localparam logic [2:0] MEMOP_WORD = 3'd0;
  localparam logic [2:0] MEMOP_BU   = 3'd1;
  localparam logic [2:0] MEMOP_HU   = 3'd2;
  localparam logic [2:0] MEMOP_BS   = 3'd3;
  localparam logic [2:0] MEMOP_HS   = 3'd4;
  typedef enum logic {IDLE, RMW_WR} state_t;
endpackage

// File: rtl/dm_access_arbiter_if.sv
// dm_access_arbiter_if: one requester's load/store handshake into the data-memory arbiter.
interface dm_access_arbiter_if;
  logic        req;
  logic        we;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        stall;
  modport master (output req, we, op, addr, wdata, input rdata, ready, err, stall);
  modport slave  (input req, we, op, addr, wdata, output rdata, ready, err, stall);
endinterface

// File: rtl/dm_lane_unit.sv
// dm_lane_unit: byte/half lane extraction with extension, store lane merge and misalign detection.
module dm_lane_unit import dm_pkg::*; (
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ldata,
  output logic [31:0] o_merged,
  output logic        o_mis
);
  logic        w_byte, w_half;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  logic [31:0] w_mask, w_data, w_shift;
  assign w_byte  = i_op == MEMOP_BU || i_op == MEMOP_BS;
  assign w_half  = i_op == MEMOP_HU || i_op == MEMOP_HS;
  assign w_shift = i_word >> {i_addr, 3'b000};
  assign w_b     = w_shift[7:0];
  assign w_h     = i_addr[1] ? i_word[31:16] : i_word[15:0];
  assign o_mis   = w_half ? i_addr[0] : (!w_byte && |i_addr);
  assign o_ldata = i_op == MEMOP_BU ? {24'd0, w_b} :
                   i_op == MEMOP_BS ? {{24{w_b[7]}}, w_b} :
                   i_op == MEMOP_HU ? {16'd0, w_h} :
                   i_op == MEMOP_HS ? {{16{w_h[15]}}, w_h} : i_word;
  // replicate the store data across lanes, then keep only the addressed lane
  assign w_mask   = w_byte ? 32'h0000_00FF << {i_addr, 3'b000} : 32'h0000_FFFF << {i_addr[1], 4'b0000};
  assign w_data   = w_byte ? {4{i_wdata[7:0]}} : {2{i_wdata[15:0]}};
  assign o_merged = (w_byte || w_half) ? ((i_word & ~w_mask) | (w_data & w_mask)) : i_wdata;
endmodule

// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter: shares the word-wide data RAM between MEM stage (a) and debug/DMA (b),
// with starvation guard for b and 2-cycle read-modify-write for sub-word stores.
module dm_access_arbiter import dm_pkg::*; #(
  parameter int AW         = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  dm_access_arbiter_if.slave   a,
  dm_access_arbiter_if.slave   b,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  state_t        r_state, w_state_n;
  logic [SW-1:0] r_starve;
  logic [31:0]   r_word;
  logic [AW-1:0] r_idx;
  logic          r_owner;
  logic          w_sel, w_act, w_we, w_sub, w_mis, w_ready, w_err, w_unused;
  logic [2:0]    w_op;
  logic [31:0]   w_addr, w_wdata, w_ldata, w_merged, w_rdata;
  // during RMW_WR the owner stays selected; in IDLE b wins only when a is idle or b is starved
  assign w_sel    = r_state == RMW_WR ? r_owner : b.req && (!a.req || r_starve == SW'(STARVE_MAX));
  assign w_act    = r_state == RMW_WR || a.req || b.req;
  assign w_we     = w_sel ? b.we    : a.we;
  assign w_op     = w_sel ? b.op    : a.op;
  assign w_addr   = w_sel ? b.addr  : a.addr;
  assign w_wdata  = w_sel ? b.wdata : a.wdata;
  assign w_sub    = w_op inside {MEMOP_BU, MEMOP_HU, MEMOP_BS, MEMOP_HS};
  assign w_unused = ^w_addr[31:AW+2];
  dm_lane_unit u_lane (
    .i_op(w_op), .i_addr(w_addr[1:0]), .i_word(mem_rdata), .i_wdata(w_wdata),
    .o_ldata(w_ldata), .o_merged(w_merged), .o_mis(w_mis)
  );
  always_comb begin
    w_state_n = IDLE;
    w_ready   = 1'b0;
    w_err     = 1'b0;
    w_rdata   = '0;
    mem_we    = 1'b0;
    mem_wdata = w_wdata;
    mem_addr  = r_state == RMW_WR ? r_idx : w_addr[AW+1:2];
    if (!reset && r_state == RMW_WR) begin
      mem_we    = 1'b1;
      mem_wdata = r_word;
      w_ready   = 1'b1;
    end else if (!reset && w_act) begin
      if (w_mis) begin
        w_ready = 1'b1;
        w_err   = 1'b1;
      end else if (!w_we) begin
        w_ready = 1'b1;
        w_rdata = w_ldata;
      end else if (!w_sub) begin
        mem_we  = 1'b1;
        w_ready = 1'b1;
      end else w_state_n = RMW_WR;
    end
  end
  assign a.ready = w_ready && !w_sel;
  assign b.ready = w_ready && w_sel;
  assign a.err   = w_err && !w_sel;
  assign b.err   = w_err && w_sel;
  assign a.rdata = w_sel ? '0 : w_rdata;
  assign b.rdata = w_sel ? w_rdata : '0;
  assign a.stall = !reset && a.req && !a.ready;
  assign b.stall = !reset && b.req && !b.ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_starve <= '0;
      r_word   <= '0;
      r_idx    <= '0;
      r_owner  <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_starve <= (!b.req || w_sel) ? '0 : r_starve == SW'(STARVE_MAX) ? r_starve : r_starve + 1'b1;
      if (r_state == IDLE && w_state_n == RMW_WR) begin
        r_word  <= w_merged;
        r_idx   <= w_addr[AW+1:2];
        r_owner <= w_sel;
      end
    end
  end
endmodule

// File: tb/tb_dm_access_arbiter.sv
// tb_dm_access_arbiter: directed vectors against a behavioural RAM, hand-computed expectations.
module tb_dm_access_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] ram [4096];
  int          checks = 0, errors = 0;
  dm_access_arbiter_if ia();
  dm_access_arbiter_if ib();
  dm_access_arbiter #(.AW(12), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset), .a(ia.slave), .b(ib.slave),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic drv_a(input logic req, input logic we, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    ia.req = req; ia.we = we; ia.op = op; ia.addr = addr; ia.wdata = wd;
  endtask
  task automatic drv_b(input logic req, input logic we, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    ib.req = req; ib.we = we; ib.op = op; ib.addr = addr; ib.wdata = wd;
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
    reset = 1'b1;
    drv_a(0, 0, 0, 0, 0);
    drv_b(0, 0, 0, 0, 0);
    nxt(); nxt();
    chk("rst_a_ready", {31'd0, ia.ready}, 0);
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_a_rdata", ia.rdata, 0);
    reset = 1'b0;
    #2;
    chk("idle_b_ready", {31'd0, ib.ready}, 0);
    nxt();
    drv_a(1, 1, 0, 32'h10, 32'hDEADBEEF);
    #2;
    chk("sw_mem_we", {31'd0, mem_we}, 1);
    chk("sw_a_ready", {31'd0, ia.ready}, 1);
    chk("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sw_mem_addr", {20'd0, mem_addr}, 32'h4);
    nxt();
    drv_a(1, 0, 0, 32'h10, 0);
    #2;
    chk("lw_mem_we", {31'd0, mem_we}, 0);
    chk("lw_a_ready", {31'd0, ia.ready}, 1);
    chk("lw_a_rdata", ia.rdata, 32'hDEADBEEF);
    nxt();
    ram[8] = 32'h11223344;
    drv_a(1, 1, 1, 32'h21, 32'h000000AB);
    #2;
    chk("sb1_a_ready", {31'd0, ia.ready}, 0);
    chk("sb1_mem_we", {31'd0, mem_we}, 0);
    chk("sb1_a_stall", {31'd0, ia.stall}, 1);
    nxt();
    #1;
    chk("sb2_mem_we", {31'd0, mem_we}, 1);
    chk("sb2_mem_wdata", mem_wdata, 32'h1122AB44);
    chk("sb2_mem_addr", {20'd0, mem_addr}, 32'h8);
    chk("sb2_a_ready", {31'd0, ia.ready}, 1);
    nxt();
    drv_a(0, 0, 0, 0, 0);
    #2;
    chk("sb_ram", ram[8], 32'h1122AB44);
    ram[12] = 32'h80FF7F01;
    nxt();
    drv_a(1, 0, 3, 32'h32, 0); #2; chk("lb_p2", ia.rdata, 32'hFFFFFFFF); nxt();
    drv_a(1, 0, 1, 32'h33, 0); #2; chk("lbu_p3", ia.rdata, 32'h00000080); nxt();
    drv_a(1, 0, 4, 32'h32, 0); #2; chk("lh_p2", ia.rdata, 32'hFFFF80FF); nxt();
    drv_a(1, 0, 2, 32'h30, 0); #2; chk("lhu_p0", ia.rdata, 32'h00007F01); nxt();
    drv_a(0, 0, 0, 0, 0);
    nxt();
    drv_a(1, 0, 0, 32'h10, 0);
    drv_b(1, 0, 0, 32'h30, 0);
    for (int c = 1; c <= 4; c++) begin
      #2;
      chk($sformatf("starve_a_rdy%0d", c), {31'd0, ia.ready}, 1);
      chk($sformatf("starve_b_rdy%0d", c), {31'd0, ib.ready}, 0);
      nxt();
    end
    #2;
    chk("starve5_b_ready", {31'd0, ib.ready}, 1);
    chk("starve5_a_ready", {31'd0, ia.ready}, 0);
    chk("starve5_a_stall", {31'd0, ia.stall}, 1);
    chk("starve5_b_rdata", ib.rdata, 32'h80FF7F01);
    nxt();
    #2;
    chk("starve6_a_ready", {31'd0, ia.ready}, 1);
    chk("starve6_a_rdata", ia.rdata, 32'hDEADBEEF);
    nxt();
    drv_b(0, 0, 0, 0, 0);
    drv_a(1, 1, 0, 32'h13, 32'h12345678);
    #2;
    chk("sw_mis_ready", {31'd0, ia.ready}, 1);
    chk("sw_mis_err", {31'd0, ia.err}, 1);
    chk("sw_mis_mem_we", {31'd0, mem_we}, 0);
    nxt();
    drv_a(1, 0, 4, 32'h21, 0);
    #2;
    chk("lh_mis_ready", {31'd0, ia.ready}, 1);
    chk("lh_mis_err", {31'd0, ia.err}, 1);
    chk("lh_mis_rdata", ia.rdata, 0);
    chk("lh_mis_mem_we", {31'd0, mem_we}, 0);
    nxt();
    drv_a(0, 0, 0, 0, 0);
    ram[16] = 32'h01234567;
    nxt();
    drv_a(1, 1, 2, 32'h40, 32'h0000BEEF);
    #2;
    chk("rsth1_a_ready", {31'd0, ia.ready}, 0);
    nxt();
    reset = 1'b1;
    #1;
    chk("rsth2_mem_we", {31'd0, mem_we}, 0);
    chk("rsth2_a_ready", {31'd0, ia.ready}, 0);
    chk("rsth2_a_stall", {31'd0, ia.stall}, 0);
    nxt();
    reset = 1'b0;
    drv_a(0, 0, 0, 0, 0);
    #2;
    chk("rsth_ram", ram[16], 32'h01234567);
    chk("rsth_idle_mem_we", {31'd0, mem_we}, 0);
    nxt();
    drv_a(1, 0, 0, 32'h40, 0);
    #2;
    chk("rsth_lw_ready", {31'd0, ia.ready}, 1);
    chk("rsth_lw_rdata", ia.rdata, 32'h01234567);
    nxt();
    drv_a(0, 0, 0, 0, 0);
    drv_b(1, 1, 2, 32'h40, 32'h0000BEEF);
    #2;
    chk("bsh1_b_ready", {31'd0, ib.ready}, 0);
    nxt();
    #1;
    chk("bsh2_b_ready", {31'd0, ib.ready}, 1);
    chk("bsh2_a_ready", {31'd0, ia.ready}, 0);
    chk("bsh2_mem_wdata", mem_wdata, 32'h0123BEEF);
    nxt();
    drv_b(0, 0, 0, 0, 0);
    #2;
    chk("bsh_ram", ram[16], 32'h0123BEEF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
